// File: rtl/pov_col_loader_if.sv
// Byte-stream handshake between the image source and the POV column loader.
// The source (master) drives byte/valid/frame_start; the loader (slave) drives byte_ready.
interface pov_col_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       frame_start;

  modport master (
    output byte_in,
    output byte_valid,
    output frame_start,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    input  frame_start,
    output byte_ready
  );
endinterface

// File: rtl/pov_col_loader.sv
// Double-buffered POV column loader: packs stream byte pairs into 16-bit columns and
// swaps display banks only at column 0. Optional checksum byte via POV_LOADER_CHECKSUM_EN.
module pov_col_loader #(
  parameter int NUM_COLS  = 256,
  parameter int LOW_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst,
  pov_col_loader_if.slave    s_stream,
  input  logic [7:0]         i_dir,
  output logic [15:0]        o_dato_ram,
  output logic               o_frame_ready,
  output logic               o_swap_pulse,
  output logic               o_load
`ifdef POV_LOADER_CHECKSUM_EN
  ,
  output logic               o_crc_err
`endif
);

  localparam int AW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [7:0] LAST_COL = 8'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FIRST     = 3'd1,
    SECOND    = 3'd2,
    WAIT_SWAP = 3'd3
`ifdef POV_LOADER_CHECKSUM_EN
    ,
    CHECK     = 3'd4
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_col;
  logic [7:0]  w_col_next;
  logic [7:0]  r_half;
  logic [7:0]  w_half_next;
  logic        r_pending;
  logic        w_pending_next;
  logic        r_rd_bank;
  logic        r_frame_ready;
  logic        r_swap_pulse;
  logic        r_load;
  logic [15:0] r_dato;
  logic        w_xfer;
  logic        w_we;
  logic        w_swap;
  logic        w_byte_ready;
  logic [15:0] w_wdata;
`ifdef POV_LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
  logic [7:0]  w_xor_next;
  logic        r_crc_err;
  logic        w_crc_err;
`endif

  logic [15:0] r_mem [2][NUM_COLS];

  assign w_xfer  = s_stream.byte_valid & w_byte_ready;
  assign w_wdata = (LOW_FIRST != 0) ? {s_stream.byte_in, r_half}
                                    : {r_half, s_stream.byte_in};

  always_comb begin
    w_next_state   = r_state;
    w_col_next     = r_col;
    w_half_next    = r_half;
    w_pending_next = r_pending;
    w_we           = 1'b0;
    w_swap         = 1'b0;
    w_byte_ready   = 1'b0;
`ifdef POV_LOADER_CHECKSUM_EN
    w_xor_next     = r_xor;
    w_crc_err      = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (s_stream.frame_start) begin
          w_next_state = FIRST;
          w_col_next   = 8'd0;
`ifdef POV_LOADER_CHECKSUM_EN
          w_xor_next   = 8'd0;
`endif
        end
      end
      FIRST: begin
        w_byte_ready = 1'b1;
        if (s_stream.frame_start) begin
          w_next_state = FIRST;
          w_col_next   = 8'd0;
`ifdef POV_LOADER_CHECKSUM_EN
          w_xor_next   = 8'd0;
`endif
        end else if (w_xfer) begin
          w_half_next  = s_stream.byte_in;
          w_next_state = SECOND;
`ifdef POV_LOADER_CHECKSUM_EN
          w_xor_next   = r_xor ^ s_stream.byte_in;
`endif
        end
      end
      SECOND: begin
        w_byte_ready = 1'b1;
        if (s_stream.frame_start) begin
          w_next_state = FIRST;
          w_col_next   = 8'd0;
`ifdef POV_LOADER_CHECKSUM_EN
          w_xor_next   = 8'd0;
`endif
        end else if (w_xfer) begin
          w_we = 1'b1;
`ifdef POV_LOADER_CHECKSUM_EN
          w_xor_next = r_xor ^ s_stream.byte_in;
`endif
          if (r_col == LAST_COL) begin
`ifdef POV_LOADER_CHECKSUM_EN
            w_next_state   = CHECK;
`else
            w_pending_next = 1'b1;
            w_next_state   = WAIT_SWAP;
`endif
          end else begin
            w_col_next   = r_col + 8'd1;
            w_next_state = FIRST;
          end
        end
      end
`ifdef POV_LOADER_CHECKSUM_EN
      CHECK: begin
        w_byte_ready = 1'b1;
        if (s_stream.frame_start) begin
          w_next_state = FIRST;
          w_col_next   = 8'd0;
          w_xor_next   = 8'd0;
        end else if (w_xfer) begin
          if (r_xor == s_stream.byte_in) begin
            w_pending_next = 1'b1;
            w_next_state   = WAIT_SWAP;
          end else begin
            w_crc_err    = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
`endif
      WAIT_SWAP: begin
        // Swap only when the display is back at column 0 so a revolution is never torn.
        if (r_pending && (i_dir == 8'd0)) begin
          w_swap         = 1'b1;
          w_pending_next = 1'b0;
          w_next_state   = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_col         <= 8'd0;
      r_half        <= 8'd0;
      r_pending     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_frame_ready <= 1'b0;
      r_swap_pulse  <= 1'b0;
      r_load        <= 1'b0;
`ifdef POV_LOADER_CHECKSUM_EN
      r_xor         <= 8'd0;
      r_crc_err     <= 1'b0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_col        <= w_col_next;
      r_half       <= w_half_next;
      r_pending    <= w_pending_next;
      r_swap_pulse <= w_swap;
      r_load       <= w_swap & ~r_frame_ready;
      if (w_swap) begin
        r_rd_bank     <= ~r_rd_bank;
        r_frame_ready <= 1'b1;
      end
`ifdef POV_LOADER_CHECKSUM_EN
      r_xor     <= w_xor_next;
      r_crc_err <= w_crc_err;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[~r_rd_bank][r_col[AW-1:0]] <= w_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dato <= 16'd0;
    end else if (!r_frame_ready || ({1'b0, i_dir} >= 9'(NUM_COLS))) begin
      r_dato <= 16'd0;
    end else begin
      r_dato <= r_mem[r_rd_bank][i_dir[AW-1:0]];
    end
  end

  assign s_stream.byte_ready = w_byte_ready;
  assign o_dato_ram          = r_dato;
  assign o_frame_ready       = r_frame_ready;
  assign o_swap_pulse        = r_swap_pulse;
  assign o_load              = r_load;
`ifdef POV_LOADER_CHECKSUM_EN
  assign o_crc_err           = r_crc_err;
`endif

endmodule

// File: tb/tb_pov_col_loader.sv
// Directed bench for pov_col_loader with NUM_COLS=4, LOW_FIRST=1; adds checksum
// steps when POV_LOADER_CHECKSUM_EN is defined.
module tb_pov_col_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  dir;
  logic [15:0] datoRam;
  logic        frameReady;
  logic        swapPulse;
  logic        loadPulse;
`ifdef POV_LOADER_CHECKSUM_EN
  logic        crcErr;
`endif

  int nAsserts = 0;
  int nFail    = 0;

  pov_col_loader_if byteIf ();

  pov_col_loader #(
    .NUM_COLS  (4),
    .LOW_FIRST (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_stream      (byteIf.slave),
    .i_dir         (dir),
    .o_dato_ram    (datoRam),
    .o_frame_ready (frameReady),
    .o_swap_pulse  (swapPulse),
    .o_load        (loadPulse)
`ifdef POV_LOADER_CHECKSUM_EN
    ,
    .o_crc_err     (crcErr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pulseFrameStart();
    byteIf.frame_start = 1'b1;
    tick();
    byteIf.frame_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int waitCycles;
    waitCycles = 0;
    byteIf.byte_in    = b;
    byteIf.byte_valid = 1'b1;
    while (!byteIf.byte_ready && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    if (waitCycles >= 20) begin
      nAsserts++;
      nFail++;
      $error("[TB] FAIL byte_ready_timeout: observed 0 expected 1 for byte %h", b);
    end else begin
      tick();
    end
    byteIf.byte_valid = 1'b0;
  endtask

  task automatic sendWords(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    sendByte(w0[7:0]); sendByte(w0[15:8]);
    sendByte(w1[7:0]); sendByte(w1[15:8]);
    sendByte(w2[7:0]); sendByte(w2[15:8]);
    sendByte(w3[7:0]); sendByte(w3[15:8]);
  endtask

  task automatic sendFrame(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    sendWords(w0, w1, w2, w3);
`ifdef POV_LOADER_CHECKSUM_EN
    sendByte(w0[7:0] ^ w0[15:8] ^ w1[7:0] ^ w1[15:8] ^
             w2[7:0] ^ w2[15:8] ^ w3[7:0] ^ w3[15:8]);
`endif
  endtask

  task automatic applyStimulus();
    // Reset with the display parked on column 5.
    rst = 1'b1;
    dir = 8'd5;
    byteIf.byte_in     = 8'h00;
    byteIf.byte_valid  = 1'b0;
    byteIf.frame_start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset_dato", datoRam, 16'h0000);
      checkOutput("reset_frame_ready", {15'd0, frameReady}, 16'd0);
      checkOutput("reset_byte_ready", {15'd0, byteIf.byte_ready}, 16'd0);
    end

    // Frame 1: columns 1..4, swap at dir==0 with first-load pulse.
    dir = 8'd3;
    pulseFrameStart();
    checkOutput("f1_byte_ready_first", {15'd0, byteIf.byte_ready}, 16'd1);
    sendFrame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    checkOutput("f1_byte_ready_wait", {15'd0, byteIf.byte_ready}, 16'd0);
    tick();
    checkOutput("f1_no_swap_dir3", {15'd0, swapPulse}, 16'd0);
    checkOutput("f1_frame_ready_pre", {15'd0, frameReady}, 16'd0);
    dir = 8'd0;
    tick();
    checkOutput("f1_swap_pulse", {15'd0, swapPulse}, 16'd1);
    checkOutput("f1_load", {15'd0, loadPulse}, 16'd1);
    checkOutput("f1_frame_ready", {15'd0, frameReady}, 16'd1);
    tick();
    checkOutput("f1_dir0", datoRam, 16'h0001);
    checkOutput("f1_swap_cleared", {15'd0, swapPulse}, 16'd0);
    checkOutput("f1_load_cleared", {15'd0, loadPulse}, 16'd0);
    dir = 8'd2;
    tick();
    checkOutput("f1_dir2", datoRam, 16'h0003);
    dir = 8'd3;
    tick();
    checkOutput("f1_dir3", datoRam, 16'h0004);
    dir = 8'd4;
    tick();
    checkOutput("f1_dir_out_of_range", datoRam, 16'h0000);

    // Frame 2 waits for dir==0; surplus bytes are refused meanwhile.
    dir = 8'd1;
    pulseFrameStart();
    sendFrame(16'h0011, 16'h0012, 16'h0013, 16'h0014);
    byteIf.byte_in    = 8'h99;
    byteIf.byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("f2_surplus_ready", {15'd0, byteIf.byte_ready}, 16'd0);
      checkOutput("f2_old_frame", datoRam, 16'h0002);
      checkOutput("f2_no_swap", {15'd0, swapPulse}, 16'd0);
    end
    byteIf.byte_valid = 1'b0;
    dir = 8'd0;
    tick();
    checkOutput("f2_swap_pulse", {15'd0, swapPulse}, 16'd1);
    checkOutput("f2_no_load", {15'd0, loadPulse}, 16'd0);
    dir = 8'd1;
    tick();
    checkOutput("f2_dir1", datoRam, 16'h0012);

    // Aborted partial frame followed by a full 0xAA55 frame.
    dir = 8'd2;
    pulseFrameStart();
    sendByte(8'h77); sendByte(8'h66); sendByte(8'h55);
    pulseFrameStart();
    sendFrame(16'hAA55, 16'hAA55, 16'hAA55, 16'hAA55);
    tick();
    checkOutput("abort_display_f2", datoRam, 16'h0013);
    dir = 8'd0;
    tick();
    checkOutput("abort_swap_pulse", {15'd0, swapPulse}, 16'd1);
    for (int c = 0; c < 4; c++) begin
      dir = 8'(c);
      tick();
      checkOutput("abort_col", datoRam, 16'hAA55);
    end

    // Asynchronous reset in the middle of a frame.
    dir = 8'd1;
    pulseFrameStart();
    for (int i = 0; i < 5; i++) sendByte(8'h5A);
    #2;
    rst = 1'b1;
    tick();
    checkOutput("rst_dato", datoRam, 16'h0000);
    checkOutput("rst_frame_ready", {15'd0, frameReady}, 16'd0);
    checkOutput("rst_byte_ready", {15'd0, byteIf.byte_ready}, 16'd0);
    rst = 1'b0;
    byteIf.byte_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("post_rst_byte_ready", {15'd0, byteIf.byte_ready}, 16'd0);
      checkOutput("post_rst_dato", datoRam, 16'h0000);
    end
    byteIf.byte_valid = 1'b0;
    pulseFrameStart();
    checkOutput("post_rst_fs_ready", {15'd0, byteIf.byte_ready}, 16'd1);

`ifdef POV_LOADER_CHECKSUM_EN
    // Good checksum swaps; bad checksum pulses crc_err and keeps the old frame.
    pulseFrameStart();
    sendWords(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    sendByte(8'h04);
    checkOutput("ck_good_no_err", {15'd0, crcErr}, 16'd0);
    dir = 8'd0;
    tick();
    checkOutput("ck_good_swap", {15'd0, swapPulse}, 16'd1);
    dir = 8'd1;
    tick();
    checkOutput("ck_good_dir1", datoRam, 16'h0002);
    pulseFrameStart();
    sendWords(16'h0021, 16'h0022, 16'h0023, 16'h0024);
    sendByte(8'h05);
    checkOutput("ck_bad_crc_err", {15'd0, crcErr}, 16'd1);
    dir = 8'd0;
    tick();
    checkOutput("ck_bad_err_cleared", {15'd0, crcErr}, 16'd0);
    checkOutput("ck_bad_no_swap", {15'd0, swapPulse}, 16'd0);
    tick();
    checkOutput("ck_bad_no_swap2", {15'd0, swapPulse}, 16'd0);
    dir = 8'd1;
    tick();
    checkOutput("ck_bad_old_dir1", datoRam, 16'h0002);
`endif
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
